// File: rtl/alu_arbiter_if.sv
// Requester-side bundle for alu_arbiter: request and response handshakes plus operand slices.
// The arbiter uses the slave modport and the requesters use the master modport.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2
) ();
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic [3*NUM_REQ-1:0] req_op;
  logic [NUM_REQ-1:0]   resp_valid;
  logic [NUM_REQ-1:0]   resp_ready;
  logic [7:0]           resp_data;
  logic                 resp_zero;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_zero
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_data, resp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one 8-bit ALU among NUM_REQ requesters through an IDLE -> EXEC -> RESP sequence.
// The optional macro ALU_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic [7:0]       alu_input_a,
  output logic [7:0]       alu_input_b,
  output logic [2:0]       alu_opcode,
  input  logic [7:0]       alu_out,
  input  logic             alu_zero,
  output logic             busy,
  output logic [PTR_W-1:0] grant_id
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("alu_arbiter: NUM_REQ must be within 2..8");
  end

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [7:0]         a_p0;
  logic [7:0]         b_p0;
  logic [2:0]         op_p0;
  logic [7:0]         data_p1;
  logic               zero_p1;
  logic [NUM_REQ-1:0] vld_p1;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] ready;
  logic               accept;

  // Search upward from the pointer, wrapping; in fixed-priority builds the pointer never leaves 0.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_found && bus.req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    ready = '0;
    if (rst_n && state == IDLE && win_found) ready[win_idx] = 1'b1;
  end

  assign accept        = |(bus.req_valid & ready);
  assign bus.req_ready = ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      a_p0     <= '0;
      b_p0     <= '0;
      op_p0    <= '0;
      data_p1  <= '0;
      zero_p1  <= 1'b0;
      vld_p1   <= '0;
    end else begin
      case (state)
        // p0: capture the winner's operands
        IDLE: begin
          if (accept) begin
            a_p0     <= bus.req_a[int'(win_idx)*8 +: 8];
            b_p0     <= bus.req_b[int'(win_idx)*8 +: 8];
            op_p0    <= bus.req_op[int'(win_idx)*3 +: 3];
            grant_id <= win_idx;
            state    <= EXEC;
          end
        end
        // p1: capture the ALU result driven from the p0 registers
        EXEC: begin
          data_p1 <= alu_out;
          zero_p1 <= alu_zero;
          vld_p1  <= NUM_REQ'(1) << grant_id;
          state   <= RESP;
        end
        RESP: begin
          if (bus.resp_ready[grant_id]) begin
            vld_p1 <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
`endif
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign alu_input_a    = a_p0;
  assign alu_input_b    = b_p0;
  assign alu_opcode     = op_p0;
  assign bus.resp_data  = data_p1;
  assign bus.resp_zero  = zero_p1;
  assign bus.resp_valid = vld_p1 & {NUM_REQ{rst_n}};
  assign busy           = (state != IDLE);

endmodule
